sa_seq_ctrl: RTL and testbench
==============================

SA_SEQ_CTRL -- requirements
Module: sa_seq_ctrl

Interface
REQ-001 Parameter ROWS, default 8: systolic array rows; also the weight-load cycle count.
REQ-002 Parameter COLS, default 8: systolic array columns.
REQ-003 Parameter CNTW, default 16: width of the stream-length input and the internal counter.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request one tile pass; sampled only in IDLE.
REQ-007 k_len  input  CNTW  number of ifm vectors to stream; captured when start is accepted.
REQ-008 abort  input  1  cancel the pass; present only when SA_SEQ_CTRL_ABORT_EN is defined.
REQ-009 en_i, clr_i  output  1 each  ifm register enable/clear to the array edge PE.
REQ-010 en_w, clr_w  output  1 each  weight register enable/clear to the array edge PE.
REQ-011 en_o, clr_o  output  1 each  accumulator enable/clear to the array edge PE.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at pass completion.

Function
REQ-014 The FSM SHALL have states IDLE, CLEAR, WLOAD, STREAM, DRAIN, DONE, and every output SHALL be a registered function of the state.
REQ-015 IDLE: start=1 -> CLEAR next cycle, with k_len latched; start in any other state SHALL be ignored.
REQ-016 CLEAR (1 cycle): clr_i=clr_w=clr_o=1 and all enables 0; then -> WLOAD.
REQ-017 WLOAD (exactly ROWS cycles): en_w=1 only; then -> STREAM, or -> DRAIN if the latched k_len==0.
REQ-018 STREAM (exactly k_len cycles): en_i=en_o=1, en_w=0; then -> DRAIN.
REQ-019 DRAIN (exactly ROWS+COLS-1 cycles): en_o=1 only, flushing the systolic skew; then -> DONE.
REQ-020 DONE (1 cycle): done=1 and all enables 0; then -> IDLE.
REQ-021 A single down-counter of CNTW bits SHALL be loaded on every phase entry with (phase length - 1), and the phase SHALL end when the counter is 0; the counter SHALL never wrap.
REQ-022 k_len = 2^CNTW-1 SHALL stream exactly 2^CNTW-1 cycles.
REQ-023 Changes on k_len after start is accepted SHALL have no effect on the current pass.
REQ-024 From start sampled high at edge 0: clr_* high after edge 1; en_w high after edges 2..ROWS+1.
REQ-025 done SHALL be high during cycle ROWS+k_len+ROWS+COLS+1 after start was sampled.
REQ-026 busy SHALL rise one cycle after start is accepted and fall in the cycle after the done pulse.
REQ-027 start held high continuously SHALL begin a new pass on the first IDLE cycle after DONE.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, counter=0, the latched k_len=0, and all outputs (en_*, clr_*, busy, done) to 0, including in the middle of a pass.
REQ-029 After reset release, the block SHALL stay in IDLE until start is sampled high.

Configuration
REQ-030 With SA_SEQ_CTRL_ABORT_EN defined, abort=1 in WLOAD, STREAM or DRAIN SHALL go to CLEAR next cycle and then directly to IDLE without a done pulse.
REQ-031 With SA_SEQ_CTRL_ABORT_EN defined, abort SHALL be ignored in IDLE, CLEAR and DONE, and abort together with start in IDLE SHALL accept the start.
REQ-032 Without SA_SEQ_CTRL_ABORT_EN defined, the abort port and its logic SHALL be absent, and CLEAR SHALL always proceed to WLOAD.

Verification
REQ-033 ROWS=COLS=4, k_len=6, start pulse -> clr_* for 1 cycle, en_w for 4, en_i/en_o for 6, en_o alone for 7, then done on cycle 19.
REQ-034 k_len=0 -> no en_i cycles; WLOAD is followed directly by 7 cycles of DRAIN, then done.
REQ-035 start held high, k_len=2 -> back-to-back passes with one IDLE cycle between each done and the next clr_* pulse.
REQ-036 rst_n low during STREAM cycle 3 -> all outputs 0 immediately; after release, IDLE holds until a new start.
REQ-037 With SA_SEQ_CTRL_ABORT_EN, abort in DRAIN -> 1 clr_* cycle, then IDLE, no done pulse, busy low.
REQ-038 Change k_len from 6 to 1 mid-pass and pulse start during STREAM -> the pass still streams 6 cycles and the extra start is ignored.

Source files
------------

// File: rtl/sa_seq_ctrl.sv
// sa_seq_ctrl: tile-pass sequencer for a ROWSxCOLS systolic array (clear, weight load, stream, drain, done).
// Optional abort input is compiled in when SA_SEQ_CTRL_ABORT_EN is defined.
module sa_seq_ctrl #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [CNTW-1:0] k_len,
`ifdef SA_SEQ_CTRL_ABORT_EN
    input  logic            abort,
`endif
    output logic            en_i,
    output logic            clr_i,
    output logic            en_w,
    output logic            clr_w,
    output logic            en_o,
    output logic            clr_o,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WLOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [CNTW-1:0] WL_LAST = CNTW'(ROWS - 1);
    localparam logic [CNTW-1:0] DR_LAST = CNTW'(ROWS + COLS - 2);
    localparam logic [CNTW-1:0] ONE     = CNTW'(1);

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] k_lat;
`ifdef SA_SEQ_CTRL_ABORT_EN
    logic            aborting;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            k_lat <= '0;
            en_i  <= 1'b0;
            clr_i <= 1'b0;
            en_w  <= 1'b0;
            clr_w <= 1'b0;
            en_o  <= 1'b0;
            clr_o <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SA_SEQ_CTRL_ABORT_EN
            aborting <= 1'b0;
`endif
        end else begin
            // Outputs decode the state of the previous cycle, so they trail the state by one clock.
            en_i  <= (state == S_STREAM);
            en_o  <= (state == S_STREAM) || (state == S_DRAIN);
            en_w  <= (state == S_WLOAD);
            clr_i <= (state == S_CLEAR);
            clr_w <= (state == S_CLEAR);
            clr_o <= (state == S_CLEAR);
            busy  <= (state != S_IDLE);
            done  <= (state == S_DONE);

`ifdef SA_SEQ_CTRL_ABORT_EN
            if (abort && (state == S_WLOAD || state == S_STREAM || state == S_DRAIN)) begin
                state    <= S_CLEAR;
                cnt      <= '0;
                aborting <= 1'b1;
            end else
`endif
            begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state <= S_CLEAR;
                            cnt   <= '0;
                            k_lat <= k_len;
                        end
                    end
                    S_CLEAR: begin
`ifdef SA_SEQ_CTRL_ABORT_EN
                        if (aborting) begin
                            state    <= S_IDLE;
                            aborting <= 1'b0;
                        end else
`endif
                        begin
                            state <= S_WLOAD;
                            cnt   <= WL_LAST;
                        end
                    end
                    S_WLOAD: begin
                        if (cnt != '0) begin
                            cnt <= cnt - ONE;
                        end else if (k_lat == '0) begin
                            state <= S_DRAIN;
                            cnt   <= DR_LAST;
                        end else begin
                            state <= S_STREAM;
                            cnt   <= k_lat - ONE;
                        end
                    end
                    S_STREAM: begin
                        if (cnt != '0) begin
                            cnt <= cnt - ONE;
                        end else begin
                            state <= S_DRAIN;
                            cnt   <= DR_LAST;
                        end
                    end
                    S_DRAIN: begin
                        if (cnt != '0) begin
                            cnt <= cnt - ONE;
                        end else begin
                            state <= S_DONE;
                            cnt   <= '0;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Bench for sa_seq_ctrl: per-pass vector table, hand-written corner sequences, and random
// stimulus checked cycle-by-cycle against a queue-based model of the output timeline.
module tb_sa_seq_ctrl;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int CNTW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [CNTW-1:0] k_len = '0;
    logic            abort = 1'b0;
    logic en_i, clr_i, en_w, clr_w, en_o, clr_o, busy, done;

    sa_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .k_len (k_len),
`ifdef SA_SEQ_CTRL_ABORT_EN
        .abort (abort),
`endif
        .en_i  (en_i),
        .clr_i (clr_i),
        .en_w  (en_w),
        .clr_w (clr_w),
        .en_o  (en_o),
        .clr_o (clr_o),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // {busy, done, en_i, clr_i, en_w, clr_w, en_o, clr_o}
    typedef logic [7:0] ow_t;
    localparam ow_t W_CLR  = 8'b1001_0101;
    localparam ow_t W_WL   = 8'b1000_1000;
    localparam ow_t W_ST   = 8'b1010_0010;
    localparam ow_t W_DR   = 8'b1000_0010;
    localparam ow_t W_DONE = 8'b1100_0000;

    ow_t got;
    assign got = {busy, done, en_i, clr_i, en_w, clr_w, en_o, clr_o};

    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 1'b0;

    // Model: a queue of future output words; an all-zero word means the block was idle last cycle.
    ow_t q[$];
    ow_t cur;
    ow_t exp_w = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            exp_w = '0;
        end else begin
            cur = (q.size() > 0) ? q.pop_front() : '0;
`ifdef SA_SEQ_CTRL_ABORT_EN
            if (abort && (cur == W_WL || cur == W_ST || cur == W_DR)) begin
                q.delete();
                q.push_back(W_CLR);
            end
`endif
            if (cur == '0 && start) begin
                q.push_back(W_CLR);
                repeat (ROWS) q.push_back(W_WL);
                for (int j = 0; j < int'(k_len); j++) q.push_back(W_ST);
                repeat (ROWS + COLS - 1) q.push_back(W_DR);
                q.push_back(W_DONE);
            end
            exp_w = cur;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (got !== exp_w) begin
                errors++;
                $display("FAIL lockstep t=%0t got %b exp %b", $time, got, exp_w);
            end
        end
    end

    task automatic chk(input string nm, input int g, input int e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", nm, g, e);
        end
    endtask

    typedef struct {
        int k;
        bit poke;
        int e_clr;
        int e_w;
        int e_st;
        int e_dr;
        int e_done;
    } vec_t;

    // One pass from a start pulse; cycle n is the cycle after the n-th edge, start sampled at edge 0.
    task automatic run_pass(input vec_t v, input int idx);
        int nc, nw, ns, nd, dc, nb;
        nc = 0; nw = 0; ns = 0; nd = 0; dc = 0; nb = 0;
        @(negedge clk);
        start = 1'b1;
        k_len = CNTW'(v.k);
        @(negedge clk);
        start = 1'b0;
        k_len = v.poke ? CNTW'(1) : CNTW'($urandom);
        for (int c = 1; c <= 400 && dc == 0; c++) begin
            @(negedge clk);
            if (clr_i && clr_w && clr_o) nc++;
            if (en_w) nw++;
            if (en_i && en_o) ns++;
            if (en_o && !en_i) nd++;
            if (done) dc = c;
            if (v.poke) start = (c == 8);
        end
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy) nb++;
        end
        chk($sformatf("v%0d_clr", idx), nc, v.e_clr);
        chk($sformatf("v%0d_wload", idx), nw, v.e_w);
        chk($sformatf("v%0d_stream", idx), ns, v.e_st);
        chk($sformatf("v%0d_drain", idx), nd, v.e_dr);
        chk($sformatf("v%0d_done_cycle", idx), dc, v.e_done);
        chk($sformatf("v%0d_idle_after", idx), nb, 0);
    endtask

    vec_t vecs[5];

    initial begin
        int d[8], cl[8];
        int ndn, ncl, nb;

        vecs[0] = '{k: 6,   poke: 1'b0, e_clr: 1, e_w: 4, e_st: 6,   e_dr: 7, e_done: 19};
        vecs[1] = '{k: 0,   poke: 1'b0, e_clr: 1, e_w: 4, e_st: 0,   e_dr: 7, e_done: 13};
        vecs[2] = '{k: 1,   poke: 1'b0, e_clr: 1, e_w: 4, e_st: 1,   e_dr: 7, e_done: 14};
        vecs[3] = '{k: 6,   poke: 1'b1, e_clr: 1, e_w: 4, e_st: 6,   e_dr: 7, e_done: 19};
        vecs[4] = '{k: 255, poke: 1'b0, e_clr: 1, e_w: 4, e_st: 255, e_dr: 7, e_done: 268};

        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(got), 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_release", int'(got), 0);

        for (int i = 0; i < 5; i++) run_pass(vecs[i], i);

        // Held start: passes back to back with exactly one idle cycle after each done.
        ndn = 0; ncl = 0;
        @(negedge clk);
        start = 1'b1;
        k_len = CNTW'(2);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done && ndn < 8) begin d[ndn] = c; ndn++; end
            if (clr_i && ncl < 8) begin cl[ncl] = c; ncl++; end
        end
        start = 1'b0;
        chk("held_pass_count", (ndn >= 2 && ncl >= 3) ? 1 : 0, 1);
        if (ndn >= 2 && ncl >= 3) begin
            chk("held_clr_to_done", d[0] - cl[0], 14);
            chk("held_gap0", cl[1] - d[0], 2);
            chk("held_gap1", cl[2] - d[1], 2);
        end
        repeat (30) @(negedge clk);

        // Reset in the third stream cycle, then stay idle without a new start.
        @(negedge clk);
        start = 1'b1;
        k_len = CNTW'(6);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_reset_streaming", int'(en_i), 1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", int'(got), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        nb = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy) nb++;
        end
        chk("idle_after_midpass_reset", nb, 0);

`ifdef SA_SEQ_CTRL_ABORT_EN
        // Abort in drain: one clear cycle, no done, back to idle.
        begin
            int nc2, nd2;
            nc2 = 0; nd2 = 0;
            @(negedge clk);
            start = 1'b1;
            k_len = CNTW'(2);
            @(negedge clk);
            start = 1'b0;
            repeat (9) @(negedge clk);
            chk("pre_abort_drain", int'(en_o && !en_i), 1);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            repeat (20) begin
                @(negedge clk);
                if (clr_i) nc2++;
                if (done) nd2++;
            end
            chk("abort_clr_cycles", nc2, 1);
            chk("abort_no_done", nd2, 0);
            chk("abort_busy_low", int'(busy), 0);
        end
`endif

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 5) == 0);
            k_len = ($urandom_range(0, 3) == 0) ? CNTW'(0) : CNTW'($urandom_range(1, 12));
`ifdef SA_SEQ_CTRL_ABORT_EN
            abort = ($urandom_range(0, 24) == 0);
`endif
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (60) @(negedge clk);
        chk("final_idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
